// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back queue feeding the two RAM write ports
// Three producers enqueue per cycle; up to two oldest entries drain per cycle.
module regfile_wb_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  in_vld,
  input  logic [2:0][ADDR_WIDTH-1:0]  in_addr,
  input  logic [2:0][DATA_WIDTH-1:0]  in_data,
  output logic                        in_rdy,
  output logic                        we1,
  output logic [ADDR_WIDTH-1:0]       waddr1,
  output logic [DATA_WIDTH-1:0]       wdata1,
  output logic                        we2,
  output logic [ADDR_WIDTH-1:0]       waddr2,
  output logic [DATA_WIDTH-1:0]       wdata2,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [1:0]            n_in, n_out;
  logic [PW-1:0]         head_p1, wr_idx;

  // Three free slots are guaranteed before any port is accepted; drain is not credited.
  assign in_rdy  = (count_q <= CW'(DEPTH - 3));
  assign head_p1 = head_q + PW'(1);

  assign we1    = (count_q != '0);
  assign we2    = (count_q >= CW'(2));
  assign waddr1 = we1 ? addr_q[head_q]  : '0;
  assign wdata1 = we1 ? data_q[head_q]  : '0;
  assign waddr2 = we2 ? addr_q[head_p1] : '0;
  assign wdata2 = we2 ? data_q[head_p1] : '0;
  assign n_out  = we2 ? 2'd2 : {1'b0, we1};

  assign count = count_q;
  assign empty = (count_q == '0);

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    n_in   = '0;
    wr_idx = tail_q;
    if (in_rdy) begin
      // Accepted ports are packed contiguously so port 0 is always the oldest.
      for (int k = 0; k < 3; k++) begin
        if (in_vld[k]) begin
          wr_idx         = tail_q + PW'(n_in);
          addr_d[wr_idx] = in_addr[k];
          data_d[wr_idx] = in_data[k];
          n_in           = n_in + 2'd1;
        end
      end
    end
    tail_d  = tail_q + PW'(n_in);
    head_d  = head_q + PW'(n_out);
    count_d = count_q + CW'(n_in) - CW'(n_out);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue
module tb_regfile_wb_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       in_vld;
  logic [2:0][4:0]  in_addr;
  logic [2:0][31:0] in_data;
  logic             in_rdy, we1, we2, empty;
  logic [4:0]       waddr1, waddr2;
  logic [31:0]      wdata1, wdata2;
  logic [3:0]       count;

  int checks = 0;
  int failures = 0;
  int issued = 0;
  int drained = 0;
  logic [36:0] sb [$];
  logic [31:0] ram [32];

  regfile_wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_addr(in_addr), .in_data(in_data),
    .in_rdy(in_rdy), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the current drain against the scoreboard, then predicts this cycle's enqueue.
  task automatic cycle();
    logic [36:0] e;
    chk("in_rdy", in_rdy, sb.size() <= 5);
    chk("count", count, sb.size());
    chk("empty", empty, sb.size() == 0);
    chk("we1", we1, sb.size() >= 1);
    chk("we2", we2, sb.size() >= 2);
    chk("count_le8", count <= 4'd8, 1);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("wr1", {waddr1, wdata1}, e);
      ram[e[36:32]] = e[31:0];
      e = sb.pop_front();
      chk("wr2", {waddr2, wdata2}, e);
      ram[e[36:32]] = e[31:0];
      drained += 2;
    end else if (sb.size() == 1) begin
      e = sb.pop_front();
      chk("wr1", {waddr1, wdata1}, e);
      ram[e[36:32]] = e[31:0];
      chk("wr2_zero", {waddr2, wdata2}, 0);
      drained += 1;
    end else begin
      chk("wr1_zero", {waddr1, wdata1}, 0);
      chk("wr2_zero", {waddr2, wdata2}, 0);
    end
    if (sb.size() + ((sb.size() >= 2) ? 0 : 0) <= 8 && (count <= 4'd5)) begin
      for (int k = 0; k < 3; k++)
        if (in_vld[k]) begin
          sb.push_back({in_addr[k], in_data[k]});
          issued++;
        end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk("drained_empty", count, 0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    reset = 1'b1;
    in_vld = '0;
    in_addr = '0;
    in_data = '0;

    // 1: reset state
    #12;
    chk("rst_we1", we1, 0);
    chk("rst_we2", we2, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // 2: single write
    in_vld = 3'b001; in_addr[0] = 5'd5; in_data[0] = 32'hA5;
    cycle();
    in_vld = '0;
    chk("t2_we1", we1, 1);
    chk("t2_waddr1", waddr1, 5);
    chk("t2_wdata1", wdata1, 32'hA5);
    chk("t2_we2", we2, 0);
    cycle();
    chk("t2_count", count, 0);

    // 3: three ports in one cycle
    in_vld = 3'b111;
    in_addr[0] = 5'd1; in_addr[1] = 5'd2; in_addr[2] = 5'd3;
    in_data[0] = 32'h10; in_data[1] = 32'h20; in_data[2] = 32'h30;
    cycle();
    in_vld = '0;
    chk("t3_waddr1_a", waddr1, 1);
    chk("t3_waddr2_a", waddr2, 2);
    cycle();
    chk("t3_waddr1_b", waddr1, 3);
    chk("t3_we2_b", we2, 0);
    cycle();

    // 4: saturate all ports; producers hold until accepted
    v = 32'h100;
    for (int i = 0; i < 20; i++) begin
      in_vld = 3'b111;
      for (int k = 0; k < 3; k++) begin
        in_data[k] = v + 32'(k);
        in_addr[k] = 5'(v + 32'(k));
      end
      chk("t4_rdy_rule", in_rdy, count <= 4'd5);
      if (count <= 4'd5) v = v + 32'd3;
      cycle();
    end
    in_vld = '0;
    drain_all();
    chk("t4_all_once", drained, issued);

    // 5: same-address pair resolves to the younger data
    in_vld = 3'b011;
    in_addr[0] = 5'd7; in_data[0] = 32'h11;
    in_addr[1] = 5'd7; in_data[1] = 32'h22;
    cycle();
    in_vld = '0;
    chk("t5_pair_we", {we1, we2}, 2'b11);
    chk("t5_wdata1", wdata1, 32'h11);
    chk("t5_wdata2", wdata2, 32'h22);
    cycle();
    chk("t5_ram7", ram[7], 32'h22);

    // 6: reset mid-operation
    in_vld = 3'b111;
    for (int i = 0; i < 10 && count != 4'd6; i++) cycle();
    in_vld = '0;
    chk("t6_fill", count, 6);
    #2 reset = 1'b1;
    #1;
    chk("t6_we1", we1, 0);
    chk("t6_we2", we2, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    sb.delete();
    @(negedge clk);
    chk("t6_hold_we1", we1, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    in_vld = 3'b001; in_addr[0] = 5'd9; in_data[0] = 32'hBEEF;
    cycle();
    in_vld = '0;
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
